// File: rtl/pipeout_readout_scheduler_pkg.sv
// rtl/pipeout_readout_scheduler_pkg.sv - shared types and helpers for the pipe-out readout scheduler
//
// Contents:
//   sched_state_t     : scheduler FSM state encoding
//   NUM_CORES_DEFAULT : default number of cores serviced
//   MAX_CORES         : widest select vector the onehot helper can build
//   onehot(idx)       : MAX_CORES-wide vector with only bit idx set
package pipeout_readout_scheduler_pkg;

    localparam int NUM_CORES_DEFAULT = 8;
    localparam int MAX_CORES         = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SCAN       = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_END   = 3'd3,
        ST_ADVANCE    = 3'd4,
        ST_DONE       = 3'd5
    } sched_state_t;

    function automatic logic [MAX_CORES-1:0] onehot(input int unsigned idx);
        logic [MAX_CORES-1:0] one;
        one = {{(MAX_CORES-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/pipeout_readout_scheduler_timeout_counter.sv
// rtl/pipeout_readout_scheduler_timeout_counter.sv - bounded wait timer for a granted burst
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count from zero (wins over enable)
//   enable     : count this cycle
//   expired    : high for the single enabled cycle in which the count is TIMEOUT_CYCLES-1
module sched_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // The owner leaves its wait state on expiry, so holding at LAST is never observed.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/pipeout_readout_scheduler.sv
// rtl/pipeout_readout_scheduler.sv - round-robin readout sequencer in front of the pipe-out arbiter
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle launch pulse, ignored while busy
//   stop         : abort request level
//   enable_mask  : cores to service (latched at start)
//   burst_len    : words per grant (latched at start)
//   rounds       : passes over all cores, 0 = until stop (latched at start)
//   req          : per-core data-ready, sampled live
//   arb_idle     : arbiter idle flag
//   core_select  : one-hot grant to the arbiter
//   num_words    : burst length presented with the grant
//   busy         : command in progress
//   done         : one-cycle completion pulse
//   err_timeout  : sticky per-core timeout flags, cleared on start
//   grant_count  : completed grants this command, saturating
//   round_count  : completed rounds this command, wrapping
module pipeout_readout_scheduler
    import pipeout_readout_scheduler_pkg::*;
#(
    parameter int NUM_CORES      = NUM_CORES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GCW            = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_CORES-1:0] enable_mask,
    input  logic [7:0]           burst_len,
    input  logic [7:0]           rounds,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 arb_idle,
    output logic [NUM_CORES-1:0] core_select,
    output logic [7:0]           num_words,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CORES-1:0] err_timeout,
    output logic [GCW-1:0]       grant_count,
    output logic [7:0]           round_count
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IW-1:0] LAST_POS = IW'(NUM_CORES - 1);
    localparam logic [IW:0]   NC_W     = (IW + 1)'(NUM_CORES);

    sched_state_t state_q, state_d;

    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        pos_q, pos_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [7:0]           blen_q, blen_d;
    logic [7:0]           rounds_q, rounds_d;

    logic [NUM_CORES-1:0] sel_d;
    logic [7:0]           nw_d;
    logic                 busy_d;
    logic                 done_d;
    logic [NUM_CORES-1:0] err_d;
    logic [GCW-1:0]       gc_d;
    logic [7:0]           rc_d;

    logic [IW:0]          idx_sum;
    logic [IW:0]          idx_wide;
    logic [IW-1:0]        idx;
    logic [NUM_CORES-1:0] grant_sel;
    logic                 eligible;
    logic                 tmr_clear;
    logic                 tmr_en;
    logic                 tmr_expired;

    // Rotating start point: idx = (rr_ptr + pos) mod NUM_CORES without a divider.
    assign idx_sum = {1'b0, rr_ptr_q} + {1'b0, pos_q};

    always_comb begin
        idx_wide = idx_sum;
        if (idx_sum >= NC_W) begin
            idx_wide = idx_sum - NC_W;
        end
    end

    assign idx       = idx_wide[IW-1:0];
    assign grant_sel = NUM_CORES'(onehot(32'(idx)));
    assign eligible  = mask_q[idx] & req[idx];

    // Timer restarts every SCAN and only runs while waiting for the arbiter to leave idle.
    assign tmr_clear = (state_q == ST_SCAN);
    assign tmr_en    = (state_q == ST_WAIT_START);

    sched_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        pos_d    = pos_q;
        mask_d   = mask_q;
        blen_d   = blen_q;
        rounds_d = rounds_q;
        sel_d    = core_select;
        nw_d     = num_words;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = err_timeout;
        gc_d     = grant_count;
        rc_d     = round_count;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d   = enable_mask;
                    blen_d   = burst_len;
                    rounds_d = rounds;
                    err_d    = '0;
                    gc_d     = '0;
                    rc_d     = '0;
                    pos_d    = '0;
                    busy_d   = 1'b1;
                    if ((burst_len == 8'd0) || (enable_mask == '0)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end

            ST_SCAN: begin
                if (stop) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sel_d   = '0;
                    nw_d    = '0;
                end else if (eligible) begin
                    sel_d   = grant_sel;
                    nw_d    = blen_q;
                    state_d = ST_WAIT_START;
                end else begin
                    state_d = ST_ADVANCE;
                end
            end

            ST_WAIT_START: begin
                // A burst already under way takes priority over abort and timeout.
                if (!arb_idle) begin
                    state_d = ST_WAIT_END;
                end else if (stop) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sel_d   = '0;
                    nw_d    = '0;
                end else if (tmr_expired) begin
                    err_d[idx] = 1'b1;
                    sel_d      = '0;
                    nw_d       = '0;
                    state_d    = ST_ADVANCE;
                end
            end

            ST_WAIT_END: begin
                // The arbiter cannot be aborted mid-burst, so stop is only honoured here.
                if (arb_idle) begin
                    sel_d = '0;
                    nw_d  = '0;
                    if (grant_count != {GCW{1'b1}}) begin
                        gc_d = grant_count + 1'b1;
                    end
                    if (stop) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end
            end

            ST_ADVANCE: begin
                if (pos_q == LAST_POS) begin
                    pos_d    = '0;
                    rr_ptr_d = (rr_ptr_q == LAST_POS) ? '0 : rr_ptr_q + 1'b1;
                    rc_d     = round_count + 8'd1;
                    if ((rounds_q != 8'd0) && ((round_count + 8'd1) == rounds_q)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    pos_d   = pos_q + 1'b1;
                    state_d = ST_SCAN;
                end
            end

            ST_DONE: begin
                sel_d   = '0;
                nw_d    = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                sel_d   = '0;
                nw_d    = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            pos_q       <= '0;
            mask_q      <= '0;
            blen_q      <= '0;
            rounds_q    <= '0;
            core_select <= '0;
            num_words   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= '0;
            grant_count <= '0;
            round_count <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            pos_q       <= pos_d;
            mask_q      <= mask_d;
            blen_q      <= blen_d;
            rounds_q    <= rounds_d;
            core_select <= sel_d;
            num_words   <= nw_d;
            busy        <= busy_d;
            done        <= done_d;
            err_timeout <= err_d;
            grant_count <= gc_d;
            round_count <= rc_d;
        end
    end

endmodule

// File: tb/tb_pipeout_readout_scheduler.sv
// tb/tb_pipeout_readout_scheduler.sv - scoreboard bench for the pipe-out readout scheduler
module tb_pipeout_readout_scheduler;

    localparam int NC        = 8;
    localparam int TMO       = 16;
    localparam int BURST_CYC = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [NC-1:0] enable_mask;
    logic [7:0]    burst_len;
    logic [7:0]    rounds;
    logic [NC-1:0] req;
    logic          arb_idle = 1'b1;
    logic [NC-1:0] core_select;
    logic [7:0]    num_words;
    logic          busy;
    logic          done;
    logic [NC-1:0] err_timeout;
    logic [15:0]   grant_count;
    logic [7:0]    round_count;

    int checks = 0;
    int errors = 0;

    int   sb_q[$];
    logic [7:0] exp_bl;
    int   model_rr = 0;

    int   done_pulses = 0;
    int   done_base   = 0;
    int   grants_seen = 0;
    int   sel_cycles  = 0;
    logic [NC-1:0] prev_sel = '0;

    logic arb_hang = 1'b0;
    int   arb_cnt  = 0;
    logic served   = 1'b0;

    always #5 clk = ~clk;

    pipeout_readout_scheduler #(
        .NUM_CORES      (NC),
        .TIMEOUT_CYCLES (TMO),
        .GCW            (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .enable_mask (enable_mask),
        .burst_len   (burst_len),
        .rounds      (rounds),
        .req         (req),
        .arb_idle    (arb_idle),
        .core_select (core_select),
        .num_words   (num_words),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .grant_count (grant_count),
        .round_count (round_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Arbiter model: accepts a grant, stays busy for BURST_CYC cycles, returns idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            arb_idle = 1'b1;
            arb_cnt  = 0;
            served   = 1'b0;
        end else if (!arb_hang) begin
            if (arb_cnt > 0) begin
                arb_cnt--;
                if (arb_cnt == 0) arb_idle = 1'b1;
            end else if (core_select != '0 && !served) begin
                arb_idle = 1'b0;
                arb_cnt  = BURST_CYC;
                served   = 1'b1;
            end
            if (core_select == '0) served = 1'b0;
        end
    end

    // Grant monitor: every new grant is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_pulses++;
            if (core_select != '0) sel_cycles++;
            if (core_select != '0 && prev_sel == '0) begin
                grants_seen++;
                if (sb_q.size() == 0) begin
                    check("grant_extra", 32'(core_select), 32'd0);
                end else begin
                    int e;
                    e = sb_q.pop_front();
                    check("grant_sel", 32'(core_select), 32'd1 << e);
                    check("grant_nw", 32'(num_words), 32'(exp_bl));
                end
            end
            prev_sel = core_select;
        end else begin
            prev_sel = '0;
        end
    end

    task automatic push_rounds(input logic [NC-1:0] m, input int rnd);
        for (int r = 0; r < rnd; r++) begin
            for (int p = 0; p < NC; p++) begin
                int i;
                i = (model_rr + p) % NC;
                if (m[i]) sb_q.push_back(i);
            end
            model_rr = (model_rr + 1) % NC;
        end
    endtask

    task automatic launch(input logic [NC-1:0] m, input logic [7:0] bl, input logic [7:0] rnd);
        @(negedge clk);
        done_base   = done_pulses;
        exp_bl      = bl;
        enable_mask = m;
        burst_len   = bl;
        rounds      = rnd;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        check({tag, "_pulse"}, done_pulses - done_base, 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int exp_gc;
        int g0;

        rst_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        enable_mask = '0;
        burst_len   = '0;
        rounds      = '0;
        req         = '1;
        exp_bl      = '0;

        repeat (3) @(negedge clk);
        check("rst_sel", 32'(core_select), 32'd0);
        check("rst_nw", 32'(num_words), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_gc", 32'(grant_count), 32'd0);
        check("rst_rc", 32'(round_count), 32'd0);
        rst_n = 1'b1;

        // Full mask, one round: cores 0..7 in order.
        push_rounds(8'hFF, 1);
        launch(8'hFF, 8'd4, 8'd1);
        finish_cmd("t1", 500, n);
        check("t1_gc", 32'(grant_count), 32'd8);
        check("t1_rc", 32'(round_count), 32'd1);
        check("t1_err", 32'(err_timeout), 32'd0);
        check("t1_sb", sb_q.size(), 32'd0);

        // Second command starts at core 1; a start pulse mid-command is ignored.
        push_rounds(8'hFF, 1);
        launch(8'hFF, 8'd4, 8'd1);
        repeat (10) @(negedge clk);
        enable_mask = 8'h01;
        burst_len   = 8'd0;
        rounds      = 8'd5;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        finish_cmd("t1b", 500, n);
        check("t1b_gc", 32'(grant_count), 32'd8);
        check("t1b_rc", 32'(round_count), 32'd1);
        check("t1b_sb", sb_q.size(), 32'd0);

        // Asynchronous reset while a burst is in flight.
        push_rounds(8'hFF, 1);
        launch(8'hFF, 8'd4, 8'd1);
        n = 0;
        while (!(grant_count >= 16'd2 && core_select != '0 && !arb_idle) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_reach", 32'(n < 300), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(core_select), 32'd0);
        check("arst_nw", 32'(num_words), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_gc", 32'(grant_count), 32'd0);
        sb_q.delete();
        model_rr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Sparse mask, two rounds: 0,2 then 2,0 after rotation.
        push_rounds(8'h05, 2);
        launch(8'h05, 8'd7, 8'd2);
        finish_cmd("t2", 500, n);
        check("t2_gc", 32'(grant_count), 32'd4);
        check("t2_rc", 32'(round_count), 32'd2);
        check("t2_sb", sb_q.size(), 32'd0);

        // Arbiter never leaves idle: grant held TMO cycles then timed out.
        arb_hang = 1'b1;
        @(negedge clk);
        sel_cycles = 0;
        push_rounds(8'h01, 1);
        launch(8'h01, 8'd4, 8'd1);
        finish_cmd("tmo", 300, n);
        check("tmo_hold", sel_cycles, TMO);
        check("tmo_err", 32'(err_timeout), 32'h01);
        check("tmo_gc", 32'(grant_count), 32'd0);
        check("tmo_sb", sb_q.size(), 32'd0);
        arb_hang = 1'b0;

        // Continuous mode, stop while core 3 is mid-burst.
        exp_gc = 0;
        for (int p = 0; p < NC; p++) begin
            int i;
            i = (model_rr + p) % NC;
            sb_q.push_back(i);
            exp_gc++;
            if (i == 3) break;
        end
        launch(8'hFF, 8'd4, 8'd0);
        n = 0;
        while (!(core_select == 8'h08 && !arb_idle) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("stop_reach", 32'(n < 300), 32'd1);
        stop = 1'b1;
        n = 0;
        while (arb_idle !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("stop_hold", 32'(core_select), 32'h08);
        check("stop_err_clr", 32'(err_timeout), 32'd0);
        g0 = grants_seen;
        finish_cmd("stop", 20, n);
        check("stop_lat", n, 32'd1);
        check("stop_gc", 32'(grant_count), exp_gc);
        stop = 1'b0;
        repeat (20) @(negedge clk);
        check("stop_nomore", grants_seen - g0, 32'd0);
        check("stop_sb", sb_q.size(), 32'd0);

        // Degenerate commands finish immediately without granting.
        g0 = grants_seen;
        launch(8'hFF, 8'd0, 8'd1);
        finish_cmd("bl0", 5, n);
        check("bl0_lat", 32'(n <= 1), 32'd1);
        launch(8'h00, 8'd4, 8'd1);
        finish_cmd("m0", 5, n);
        check("m0_lat", 32'(n <= 1), 32'd1);
        check("degen_nogrant", grants_seen - g0, 32'd0);
        check("degen_gc", 32'(grant_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
